// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the encoder arbiter slice.
//   - default info/codeword widths
//   - encoder work-mode encoding
//   - arbiter FSM state encoding
package enc_pkg;

  localparam int MAX_CODEWORD_WIDTH_DEF = 32;
  localparam int MAX_INFO_WIDTH_DEF     = 26;

  // Encoder work mode as seen on req*_mode / enc_work_mod.
  typedef enum logic [1:0] {
    MODE_8_4     = 2'b00,
    MODE_16_11   = 2'b01,
    MODE_32_26   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_t;

  // Arbiter FSM: IDLE arbitrates, ENC lets the encoder sample the held
  // issue registers, RESP presents the result until it is taken.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin grant.
//   valid[1:0] : request valid per requester
//   rr         : requester that currently has priority
//   en         : grant enable (grants are forced to 0 when low)
//   gnt[1:0]   : one-hot grant (or 0)
// A lone valid requester is granted regardless of rr; under contention the
// requester named by rr wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr,
  input  logic       en,
  output logic [1:0] gnt
);

  assign gnt[0] = en & valid[0] & (~valid[1] | ~rr);
  assign gnt[1] = en & valid[1] & (~valid[0] |  rr);

endmodule

// File: rtl/enc_arbiter.sv
// enc_arbiter: arbitrates two requesters onto one external encoder stage
// (encoder has a registered output, one cycle of latency) and returns the
// codeword tagged with the requester index.
//
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   req_valid/ready    : per-requester request handshake (index 0/1)
//   req0/1_data, _mode : info word and work mode per requester
//   enc_data_in        : held info word to the encoder stage
//   enc_work_mod       : held work mode to the encoder stage
//   enc_data_out       : registered encoder result
//   res_valid/ready    : result handshake
//   res_data, res_id   : codeword and owning requester
//   res_err            : illegal-mode flag
//   state_dbg          : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. Ready never depends on anything latched without a handshake; a source
// may drop valid before it is granted without losing or creating a request.
//
// Build option: define ENC_ARB_MODE_CHECK_EN to short-circuit mode 2'b11
// requests straight to RESP with res_err=1 and res_data=0 (enc_work_mod keeps
// its previous value). Without it, mode 2'b11 goes through the encoder and
// res_err is tied 0.
module enc_arbiter
  import enc_pkg::*;
#(
  parameter int MAX_CODEWORD_WIDTH = MAX_CODEWORD_WIDTH_DEF,
  parameter int MAX_INFO_WIDTH     = MAX_INFO_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [MAX_INFO_WIDTH-1:0]     req0_data,
  input  logic [MAX_INFO_WIDTH-1:0]     req1_data,
  input  logic [1:0]                    req0_mode,
  input  logic [1:0]                    req1_mode,
  output logic [MAX_INFO_WIDTH-1:0]     enc_data_in,
  output logic [1:0]                    enc_work_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] enc_data_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] res_data,
  output logic                          res_id,
  output logic                          res_err,
  output state_t                        state_dbg
);

  state_t                    state;
  logic                      rr;
  logic [MAX_INFO_WIDTH-1:0] iss_data;
  logic [1:0]                iss_mode;
  logic                      iss_id;
  logic [1:0]                gnt;
  logic                      arb_en;
  logic [MAX_INFO_WIDTH-1:0] acc_data;
  logic [1:0]                acc_mode;
  logic                      acc_illegal;
  logic                      in_resp;

  // Grants only in IDLE and never while reset is asserted, so req_ready is 0
  // during reset regardless of req_valid.
  assign arb_en = rst & (state == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .rr    (rr),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign acc_data  = gnt[1] ? req1_data : req0_data;
  assign acc_mode  = gnt[1] ? req1_mode : req0_mode;

`ifdef ENC_ARB_MODE_CHECK_EN
  logic iss_err;
  assign acc_illegal = (acc_mode == MODE_ILLEGAL);
`else
  assign acc_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rr       <= 1'b0;
      iss_data <= '0;
      iss_mode <= '0;
      iss_id   <= 1'b0;
`ifdef ENC_ARB_MODE_CHECK_EN
      iss_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            iss_data <= acc_data;
            iss_id   <= gnt[1];
            rr       <= ~gnt[1];
`ifdef ENC_ARB_MODE_CHECK_EN
            iss_err  <= acc_illegal;
`endif
            if (acc_illegal) begin
              // The encoder is bypassed, so its mode input is left untouched.
              state <= ST_RESP;
            end else begin
              iss_mode <= acc_mode;
              state    <= ST_ENC;
            end
          end
        end
        ST_ENC:  state <= ST_RESP;
        ST_RESP: if (res_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign enc_data_in  = iss_data;
  assign enc_work_mod = iss_mode;
  assign state_dbg    = state;

  // Result outputs are decoded from the state register; enc_data_out is
  // already registered in the encoder and stays stable because its inputs are
  // held by the issue registers.
  assign in_resp   = (state == ST_RESP);
  assign res_valid = in_resp;
  assign res_id    = in_resp & iss_id;

`ifdef ENC_ARB_MODE_CHECK_EN
  assign res_err  = in_resp & iss_err;
  assign res_data = (in_resp && !iss_err) ? enc_data_out : '0;
`else
  assign res_err  = 1'b0;
  assign res_data = in_resp ? enc_data_out : '0;
`endif

endmodule
